// File: rtl/ecc_key_fetch.sv
// ecc_key_fetch: streams one 176-bit private key out of the key ROM as WORDS
// 16-bit words (MS word first) into the ECC control stage. Reads are issued
// back-to-back over a fixed-latency pipelined ROM port. A valid pipe that
// tracks the ROM latency marks each returning word with a shift strobe.
// After the last word, the block emits a single-cycle done pulse.
// A session time-up aborts the fetch at any point.
module ecc_key_fetch #(
    parameter int unsigned WORDS      = 11,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned ROM_LAT    = 1,   // legal range 1..4
    parameter int unsigned KEY_BASE   = 0,
    parameter int unsigned KEY_STRIDE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load_key,
    input  logic [1:0]        i_key_sel,
    input  logic              i_time_up,
    output logic              o_rom_rd_en,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_key_shift,
    output logic [15:0]       o_data_rom_16bits,
    output logic              o_done_key,
    output logic              o_busy
);

    localparam int unsigned CntW = $clog2(WORDS + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   base_q;
    logic [CntW-1:0]     issue_cnt_q;
    logic [CntW-1:0]     ret_cnt_q;
    logic [ROM_LAT-1:0]  vld_pipe_q;
    logic [ROM_LAT-1:0]  vld_pipe_d;
    logic [ADDR_W-1:0]   sel_base;

    // Slot base address; wraps modulo the ROM address space.
    always_comb sel_base = ADDR_W'(KEY_BASE + 32'(i_key_sel) * KEY_STRIDE);

    // The ROM data bus is forwarded untouched; o_key_shift qualifies it.
    assign o_data_rom_16bits = i_rom_data;
    assign o_key_shift       = vld_pipe_q[ROM_LAT-1];

    generate
        if (ROM_LAT == 1) begin : g_pipe_one
            assign vld_pipe_d = o_rom_rd_en;
        end else begin : g_pipe_multi
            assign vld_pipe_d = {vld_pipe_q[ROM_LAT-2:0], o_rom_rd_en};
        end
    endgenerate

    // Valid pipe mirrors the ROM latency. Flushing it on abort drops in-flight reads.
    always_ff @(posedge clk) begin
        if (rst || i_time_up) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
        end
    end

    // Fetch FSM with registered read-port, done and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            o_rom_rd_en <= 1'b0;
            o_rom_addr  <= '0;
            o_done_key  <= 1'b0;
            o_busy      <= 1'b0;
        end else if (i_time_up) begin
            // A done pulse already on the outputs has completed by this edge.
            state_q     <= StIdle;
            o_rom_rd_en <= 1'b0;
            o_done_key  <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    o_done_key <= 1'b0;
                    if (i_load_key) begin
                        // Word 0 is issued on this edge, so the issue count starts at 1.
                        state_q     <= StIssue;
                        base_q      <= sel_base;
                        issue_cnt_q <= CntW'(1);
                        ret_cnt_q   <= '0;
                        o_rom_rd_en <= 1'b1;
                        o_rom_addr  <= sel_base;
                        o_busy      <= 1'b1;
                    end
                end
                StIssue: begin
                    if (o_key_shift) begin
                        ret_cnt_q <= ret_cnt_q + CntW'(1);
                    end
                    if (issue_cnt_q == CntW'(WORDS)) begin
                        // Address is left on its last value while draining.
                        state_q     <= StDrain;
                        o_rom_rd_en <= 1'b0;
                    end else begin
                        o_rom_addr  <= base_q + ADDR_W'(issue_cnt_q);
                        issue_cnt_q <= issue_cnt_q + CntW'(1);
                    end
                end
                StDrain: begin
                    if (o_key_shift) begin
                        ret_cnt_q <= ret_cnt_q + CntW'(1);
                        // Done goes out in the cycle right after the last strobe.
                        if (ret_cnt_q == CntW'(WORDS - 1)) begin
                            state_q    <= StDone;
                            o_done_key <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q    <= StIdle;
                    o_done_key <= 1'b0;
                    o_busy     <= 1'b0;
                end
                default: begin
                    state_q     <= StIdle;
                    o_rom_rd_en <= 1'b0;
                    o_done_key  <= 1'b0;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_key_fetch.sv
// Bench for ecc_key_fetch: four instances with different latency/base settings,
// each fed by its own behavioural ROM model, checked cycle by cycle.
module tb_ecc_key_fetch;

    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;
    localparam int unsigned LAT_C = 2;
    localparam int unsigned LAT_D = 1;

    logic clk;
    logic rst;

    logic a_load, a_tu, a_rd, a_shift, a_done, a_busy;
    logic b_load, b_tu, b_rd, b_shift, b_done, b_busy;
    logic c_load, c_tu, c_rd, c_shift, c_done, c_busy;
    logic d_load, d_tu, d_rd, d_shift, d_done, d_busy;
    logic [1:0]  a_sel, b_sel, c_sel, d_sel;
    logic [7:0]  a_addr, b_addr, c_addr, d_addr;
    logic [15:0] a_rdata, b_rdata, c_rdata, d_rdata;
    logic [15:0] a_data, b_data, c_data, d_data;
    logic [7:0]  a_ap[4];
    logic [7:0]  b_ap[4];
    logic [7:0]  c_ap[4];
    logic [7:0]  d_ap[4];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        load;
        logic        rd;
        logic [7:0]  addr;
        logic        shift;
        logic [15:0] data;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vec[16];

    function automatic logic [15:0] rom(input logic [7:0] a);
        return 16'hA000 + {8'h00, a};
    endfunction

    task automatic chk(input string name, input int cyc, input logic [175:0] act,
                       input logic [175:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    ecc_key_fetch #(.ROM_LAT(LAT_A)) u_a (
        .clk(clk), .rst(rst), .i_load_key(a_load), .i_key_sel(a_sel), .i_time_up(a_tu),
        .o_rom_rd_en(a_rd), .o_rom_addr(a_addr), .i_rom_data(a_rdata),
        .o_key_shift(a_shift), .o_data_rom_16bits(a_data), .o_done_key(a_done),
        .o_busy(a_busy)
    );
    ecc_key_fetch #(.ROM_LAT(LAT_B)) u_b (
        .clk(clk), .rst(rst), .i_load_key(b_load), .i_key_sel(b_sel), .i_time_up(b_tu),
        .o_rom_rd_en(b_rd), .o_rom_addr(b_addr), .i_rom_data(b_rdata),
        .o_key_shift(b_shift), .o_data_rom_16bits(b_data), .o_done_key(b_done),
        .o_busy(b_busy)
    );
    ecc_key_fetch #(.ROM_LAT(LAT_C)) u_c (
        .clk(clk), .rst(rst), .i_load_key(c_load), .i_key_sel(c_sel), .i_time_up(c_tu),
        .o_rom_rd_en(c_rd), .o_rom_addr(c_addr), .i_rom_data(c_rdata),
        .o_key_shift(c_shift), .o_data_rom_16bits(c_data), .o_done_key(c_done),
        .o_busy(c_busy)
    );
    ecc_key_fetch #(.ROM_LAT(LAT_D), .KEY_BASE(8'hF8)) u_d (
        .clk(clk), .rst(rst), .i_load_key(d_load), .i_key_sel(d_sel), .i_time_up(d_tu),
        .o_rom_rd_en(d_rd), .o_rom_addr(d_addr), .i_rom_data(d_rdata),
        .o_key_shift(d_shift), .o_data_rom_16bits(d_data), .o_done_key(d_done),
        .o_busy(d_busy)
    );

    // Fixed-latency ROM models: the address is registered LAT times.
    always @(posedge clk) begin
        a_ap[0] <= a_addr; b_ap[0] <= b_addr; c_ap[0] <= c_addr; d_ap[0] <= d_addr;
        for (int i = 1; i < 4; i++) begin
            a_ap[i] <= a_ap[i-1]; b_ap[i] <= b_ap[i-1];
            c_ap[i] <= c_ap[i-1]; d_ap[i] <= d_ap[i-1];
        end
    end
    assign a_rdata = rom(a_ap[LAT_A-1]);
    assign b_rdata = rom(b_ap[LAT_B-1]);
    assign c_rdata = rom(c_ap[LAT_C-1]);
    assign d_rdata = rom(d_ap[LAT_D-1]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        logic [175:0] got_key;
        logic [175:0] exp_key;
        logic [7:0]   ea;
        int           nsh;
        int           ndone;

        rst = 1'b1;
        {a_load, a_tu, b_load, b_tu, c_load, c_tu, d_load, d_tu} = '0;
        a_sel = 2'd0; b_sel = 2'd0; c_sel = 2'd0; d_sel = 2'd0;

        // Expected per-cycle outputs: slot 0, ROM_LAT=1.
        for (int n = 0; n < 16; n++) begin
            vec[n].load  = (n == 0);
            vec[n].rd    = (n >= 1 && n <= 11);
            vec[n].addr  = (n >= 1 && n <= 11) ? 8'(n - 1) : 8'd10;
            vec[n].shift = (n >= 2 && n <= 12);
            vec[n].data  = vec[n].shift ? 16'hA000 + 16'(n - 2) : 16'h0000;
            vec[n].done  = (n == 13);
            vec[n].busy  = (n >= 1 && n <= 13);
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_rd",    0, {a_rd, b_rd, c_rd, d_rd}, 4'b0);
        chk("reset_shift", 0, {a_shift, b_shift, c_shift, d_shift}, 4'b0);
        chk("reset_done",  0, {a_done, b_done, c_done, d_done}, 4'b0);
        chk("reset_busy",  0, {a_busy, b_busy, c_busy, d_busy}, 4'b0);
        chk("reset_addr",  0, {a_addr, b_addr, c_addr, d_addr}, 32'h0);

        // Pass 0: plain fetch. Pass 1: extra load pulses in cycles 1, 5, 12.
        for (int p = 0; p < 2; p++) begin
            nsh = 0; ndone = 0;
            for (int n = 0; n < 16; n++) begin
                @(negedge clk);
                a_load = vec[n].load | (p == 1 && (n == 1 || n == 5 || n == 12));
                chk("a_rd",    n, a_rd,    vec[n].rd);
                chk("a_shift", n, a_shift, vec[n].shift);
                chk("a_done",  n, a_done,  vec[n].done);
                chk("a_busy",  n, a_busy,  vec[n].busy);
                if (n >= 1 && n <= 13) chk("a_addr", n, a_addr, vec[n].addr);
                if (vec[n].shift) chk("a_data", n, a_data, vec[n].data);
                nsh   += int'(a_shift);
                ndone += int'(a_done);
            end
            a_load = 1'b0;
            chk("a_strobe_count", p, nsh, 11);
            chk("a_done_count",   p, ndone, 1);
        end

        // Slot 2, ROM_LAT=3: collect the 176-bit key.
        @(negedge clk);
        b_load = 1'b1; b_sel = 2'd2;
        got_key = '0;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            b_load = 1'b0;
            chk("b_rd", n, b_rd, (n <= 11));
            if (n <= 11) chk("b_addr", n, b_addr, 8'(32 + n - 1));
            chk("b_shift", n, b_shift, (n >= 4 && n <= 14));
            chk("b_done",  n, b_done,  (n == 15));
            chk("b_busy",  n, b_busy,  (n <= 15));
            if (b_shift) got_key = {got_key[159:0], b_data};
        end
        exp_key = '0;
        for (int k = 0; k < 11; k++) exp_key = {exp_key[159:0], rom(8'(32 + k))};
        chk("b_key", 0, got_key, exp_key);

        // ROM_LAT=2, time-up in cycle 6.
        @(negedge clk);
        c_load = 1'b1; c_sel = 2'd0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            c_load = 1'b0;
            c_tu   = (n == 6);
            chk("c_tu_rd",    n, c_rd,    (n <= 6));
            chk("c_tu_shift", n, c_shift, (n >= 3 && n <= 6));
            chk("c_tu_done",  n, c_done,  1'b0);
            chk("c_tu_busy",  n, c_busy,  (n <= 6));
        end
        c_tu = 1'b0;

        // Fresh fetch after the abort.
        @(negedge clk);
        c_load = 1'b1;
        nsh = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            c_load = 1'b0;
            chk("c_re_done", n, c_done, (n == 14));
            chk("c_re_busy", n, c_busy, (n <= 14));
            if (c_shift) begin
                chk("c_re_data", n, c_data, rom(8'(nsh)));
                nsh++;
            end
        end
        chk("c_re_strobe_count", 0, nsh, 11);

        // Load and time-up together in idle.
        @(negedge clk);
        c_load = 1'b1; c_tu = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            c_load = 1'b0; c_tu = 1'b0;
            chk("c_both_rd",   n, c_rd,   1'b0);
            chk("c_both_busy", n, c_busy, 1'b0);
        end

        // KEY_BASE=F8: addresses wrap past FF.
        @(negedge clk);
        d_load = 1'b1; d_sel = 2'd0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            d_load = 1'b0;
            chk("d_rd", n, d_rd, (n <= 11));
            if (n <= 11) begin
                ea = 8'hF8 + 8'(n - 1);
                chk("d_addr", n, d_addr, ea);
            end
            chk("d_shift", n, d_shift, (n >= 2 && n <= 12));
            if (n >= 2 && n <= 12) begin
                ea = 8'hF8 + 8'(n - 2);
                chk("d_data", n, d_data, rom(ea));
            end
            chk("d_done", n, d_done, (n == 13));
        end

        // Reset in the middle of a fetch clears everything.
        @(negedge clk);
        a_load = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            a_load = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rd",    5, a_rd,    1'b0);
        chk("rst_mid_shift", 5, a_shift, 1'b0);
        chk("rst_mid_busy",  5, a_busy,  1'b0);
        chk("rst_mid_addr",  5, a_addr,  8'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_idle_shift", 8, a_shift, 1'b0);
        chk("rst_mid_idle_done",  8, a_done,  1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
